psum_accumulator: RTL and testbench

Temporal accumulation stage that sits directly downstream of a `fusion_unit`. It consumes the unit's 8-bit `psum_fwd` stream one beat per cycle and sign- or zero-extends each beat. It sums a programmable number of beats into one wide result, then presents that result on a valid/ready output. It has one result register, so the next window accumulates while the previous result waits. Backpressure only stalls the beat that would complete a window.

---
 rtl/psum_accumulator.sv | 110 +++++++++++
 tb/tb_psum_accumulator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Temporal accumulator for the fusion_unit psum_fwd stream. It sums a
// programmable window of extended beats into one result held in a valid/ready output register.
module psum_accumulator #(
  parameter int PSUM_W = 8,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  input  logic              psum_signed,
  output logic              psum_ready,
  input  logic [CNT_W-1:0]  len,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]   acc_out_reg, acc_out_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   target_reg, target_next;
  logic               acc_valid_reg, acc_valid_next;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   window_sum;
  logic               last;
  logic               accept;

  // The extension bit is the sign bit only for signed beats.
  assign ext = {{(ACC_W-PSUM_W){psum_signed & psum_in[PSUM_W-1]}}, psum_in};

  always_comb begin
    last       = 1'b0;
    window_sum = ext;
    if (state_reg == IDLE) begin
      last = (len <= CNT_W'(1));
    end else begin
      last       = ((CNT_W+1)'(cnt_reg) + (CNT_W+1)'(1)) == (CNT_W+1)'(target_reg);
      window_sum = acc_reg + ext;
    end
  end

  // Only a completing beat can be stalled, and only by an undrained result.
  assign psum_ready = !flush && !(last && acc_valid_reg && !acc_ready);
  assign accept     = psum_valid && psum_ready;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    target_next    = target_reg;
    acc_out_next   = acc_out_reg;
    acc_valid_next = acc_valid_reg;

    if (acc_valid_reg && acc_ready) begin
      acc_valid_next = 1'b0;
    end

    if (flush) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
    end else if (accept) begin
      if (last) begin
        acc_out_next   = window_sum;
        acc_valid_next = 1'b1;
        state_next     = IDLE;
        acc_next       = '0;
        cnt_next       = '0;
      end else if (state_reg == IDLE) begin
        acc_next    = ext;
        cnt_next    = CNT_W'(1);
        target_next = len;
        state_next  = ACC;
      end else begin
        acc_next = window_sum;
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      target_reg    <= '0;
      acc_out_reg   <= '0;
      acc_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      target_reg    <= target_next;
      acc_out_reg   <= acc_out_next;
      acc_valid_reg <= acc_valid_next;
    end
  end

  assign acc_out   = acc_out_reg;
  assign acc_valid = acc_valid_reg;
  assign busy      = (state_reg == ACC);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed table-driven bench for psum_accumulator: per-beat vectors with
// hand-computed ready/result/busy expectations, plus an async-reset sequence.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  psum_in;
  logic        psum_valid;
  logic        psum_signed;
  logic        psum_ready;
  logic [7:0]  len;
  logic        flush;
  logic [19:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  psum_accumulator #(.PSUM_W(8), .CNT_W(8), .ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_signed(psum_signed), .psum_ready(psum_ready), .len(len), .flush(flush),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        sgn;
    logic [7:0]  din;
    logic [7:0]  len;
    logic        flush;
    logic        ardy;
    logic        e_rdy;
    logic [19:0] e_out;
    logic        e_av;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic valid, logic sgn, logic [7:0] din, logic [7:0] ln,
                              logic fl, logic ardy, logic e_rdy, logic [19:0] e_out,
                              logic e_av, logic e_busy);
    vec_t t;
    t.valid = valid; t.sgn = sgn; t.din = din; t.len = ln; t.flush = fl; t.ardy = ardy;
    t.e_rdy = e_rdy; t.e_out = e_out; t.e_av = e_av; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle: check combinational ready mid-cycle, registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    psum_valid  = v.valid;
    psum_signed = v.sgn;
    psum_in     = v.din;
    len         = v.len;
    flush       = v.flush;
    acc_ready   = v.ardy;
    #2;
    chk("psum_ready", idx, 20'(psum_ready), 20'(v.e_rdy));
    @(posedge clk);
    #1;
    chk("acc_out", idx, acc_out, v.e_out);
    chk("acc_valid", idx, 20'(acc_valid), 20'(v.e_av));
    chk("busy", idx, 20'(busy), 20'(v.e_busy));
    $display("step %0d: v=%0b in=%h len=%0d fl=%0b ardy=%0b -> rdy=%0b out=%h av=%0b busy=%0b",
             idx, v.valid, v.din, v.len, v.flush, v.ardy, psum_ready, acc_out, acc_valid, busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Unsigned sum, len=4
    vecs.push_back(mk(1,0,8'd10,8'd4,0,1, 1,20'd0,0,1));
    vecs.push_back(mk(1,0,8'd20,8'd4,0,1, 1,20'd0,0,1));
    vecs.push_back(mk(1,0,8'd30,8'd4,0,1, 1,20'd0,0,1));
    vecs.push_back(mk(1,0,8'd40,8'd4,0,1, 1,20'd100,1,0));
    vecs.push_back(mk(0,0,8'd0,8'd4,0,1, 1,20'd100,0,0));
    // Signed sum, len=3: -1 + -128 + 5 = -124
    vecs.push_back(mk(1,1,8'hFF,8'd3,0,1, 1,20'd100,0,1));
    vecs.push_back(mk(1,1,8'h80,8'd3,0,1, 1,20'd100,0,1));
    vecs.push_back(mk(1,1,8'h05,8'd3,0,1, 1,20'hFFF84,1,0));
    // Same beats unsigned: 255 + 128 + 5 = 388
    vecs.push_back(mk(1,0,8'hFF,8'd3,0,1, 1,20'hFFF84,0,1));
    vecs.push_back(mk(1,0,8'h80,8'd3,0,1, 1,20'hFFF84,0,1));
    vecs.push_back(mk(1,0,8'h05,8'd3,0,1, 1,20'h00184,1,0));
    // Degenerate lengths 0 and 1: one result per cycle
    vecs.push_back(mk(1,0,8'h7F,8'd0,0,1, 1,20'd127,1,0));
    vecs.push_back(mk(1,0,8'h7F,8'd0,0,1, 1,20'd127,1,0));
    vecs.push_back(mk(1,0,8'h7F,8'd1,0,1, 1,20'd127,1,0));
    vecs.push_back(mk(1,0,8'h7F,8'd1,0,1, 1,20'd127,1,0));
    // Backpressure with two len=2 windows
    vecs.push_back(mk(0,0,8'd0,8'd2,0,1, 1,20'd127,0,0));
    vecs.push_back(mk(1,0,8'd1,8'd2,0,0, 1,20'd127,0,1));
    vecs.push_back(mk(1,0,8'd2,8'd2,0,0, 1,20'd3,1,0));
    vecs.push_back(mk(1,0,8'd3,8'd2,0,0, 1,20'd3,1,1));
    vecs.push_back(mk(1,0,8'd4,8'd2,0,0, 0,20'd3,1,1));
    vecs.push_back(mk(1,0,8'd4,8'd2,0,1, 1,20'd7,1,0));
    vecs.push_back(mk(0,0,8'd0,8'd2,0,1, 1,20'd7,0,0));
    // Flush drops the beat and aborts the window
    vecs.push_back(mk(1,0,8'd50,8'd4,0,1, 1,20'd7,0,1));
    vecs.push_back(mk(1,0,8'd50,8'd4,0,1, 1,20'd7,0,1));
    vecs.push_back(mk(1,0,8'd50,8'd4,1,1, 0,20'd7,0,0));
    vecs.push_back(mk(1,0,8'd1,8'd4,0,1, 1,20'd7,0,1));
    vecs.push_back(mk(1,0,8'd1,8'd4,0,1, 1,20'd7,0,1));
    vecs.push_back(mk(1,0,8'd1,8'd4,0,1, 1,20'd7,0,1));
    vecs.push_back(mk(1,0,8'd1,8'd4,0,1, 1,20'd4,1,0));
    vecs.push_back(mk(0,0,8'd0,8'd4,0,1, 1,20'd4,0,0));

    rst_n = 1'b0; psum_in = '0; psum_valid = 1'b0; psum_signed = 1'b0;
    len = 8'd4; flush = 1'b0; acc_ready = 1'b1;
    #3;
    chk("reset acc_out", 0, acc_out, 20'd0);
    chk("reset acc_valid", 0, 20'(acc_valid), 20'd0);
    chk("reset busy", 0, 20'(busy), 20'd0);
    chk("reset psum_ready", 0, 20'(psum_ready), 20'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Async reset with a pending result and a window in progress
    apply(mk(1,0,8'd9,8'd1,0,0, 1,20'd9,1,0), 100);
    apply(mk(1,0,8'd1,8'd3,0,0, 1,20'd9,1,1), 101);
    psum_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async acc_valid", 102, 20'(acc_valid), 20'd0);
    chk("async acc_out", 102, acc_out, 20'd0);
    chk("async busy", 102, 20'(busy), 20'd0);
    chk("async psum_ready", 102, 20'(psum_ready), 20'd1);
    $display("step 102: async reset -> out=%h av=%0b busy=%0b", acc_out, acc_valid, busy);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(mk(1,0,8'd5,8'd2,0,1, 1,20'd0,0,1), 103);
    apply(mk(1,0,8'd6,8'd2,0,1, 1,20'd11,1,0), 104);
    apply(mk(0,0,8'd0,8'd2,0,1, 1,20'd11,0,0), 105);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
